// File: rtl/pwm_peripheral_pkg.sv
// Shared constants and helpers for the PWM peripheral.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pwm_peripheral_pkg;

  localparam int unsigned PWM_WIDTH        = 8;
  localparam int unsigned NUM_OUTPUTS      = 16;
  localparam int unsigned PRESCALE_DEFAULT = 13;

  typedef logic [PWM_WIDTH-1:0]   pwm_cnt_t;
  typedef logic [NUM_OUTPUTS-1:0] pwm_vec_t;

  // Full-scale duty forces the level high so 100 % never shows the
  // single low count that a plain "cnt < duty" compare would give.
  function automatic logic pwm_compare(input pwm_cnt_t cnt, input pwm_cnt_t duty);
    return (duty == {PWM_WIDTH{1'b1}}) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Prescaler: divides clk into one-cycle ticks, one every PRESCALE cycles.
// Latency: tick asserted combinationally in the cycle the count is PRESCALE-1.
// Backpressure: none; free-running.
// Ports: clk, rst_n (async active-low), tick (out, 1 bit).
module pwm_prescaler #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] presc_cnt;

  // With PRESCALE == 1 LAST is 0, the count never leaves 0 and tick is
  // permanently high.
  assign tick = (presc_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-output PWM peripheral with a shared 8-bit period counter and a duty
// shadow register reloaded only at period start (glitch-free duty updates).
// Latency: out is registered, 1 clk from enables/level; no backpressure.
// Ports: clk, rst_n, en_reg_out_*/en_reg_pwm_* (8b each), pwm_duty_cycle (8b),
//        out (16b, registered), period_start (1b pulse, first cycle of period).
module pwm_peripheral
  import pwm_peripheral_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             en_reg_out_7_0,
  input  logic [7:0]             en_reg_out_15_8,
  input  logic [7:0]             en_reg_pwm_7_0,
  input  logic [7:0]             en_reg_pwm_15_8,
  input  logic [PWM_WIDTH-1:0]   pwm_duty_cycle,
  output logic [NUM_OUTPUTS-1:0] out,
  output logic                   period_start
);

  logic     tick;
  logic     presc_zero;
  pwm_cnt_t period_cnt;
  pwm_cnt_t duty_shadow;
  logic     start_cycle;
  logic     pwm_level;
  pwm_vec_t en_out;
  pwm_vec_t en_pwm;
  pwm_vec_t out_nxt;

  pwm_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // The prescaler wraps to 0 on the edge that ends a tick cycle, so
  // "prescaler == 0" is simply "a tick happened last cycle" (or reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_zero <= 1'b1;
    end else begin
      presc_zero <= tick;
    end
  end

  assign start_cycle  = presc_zero && (period_cnt == '0);
  // Gated with rst_n so the pulse stays low while reset is held, even
  // though both counters already sit at zero.
  assign period_start = rst_n && start_cycle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
    end else if (tick) begin
      period_cnt <= period_cnt + pwm_cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow <= '0;
    end else if (start_cycle) begin
      duty_shadow <= pwm_duty_cycle;
    end
  end

  assign pwm_level = pwm_compare(period_cnt, duty_shadow);

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // Disabled -> 0, enabled static -> 1, enabled PWM -> shared level.
  assign out_nxt = en_out & (~en_pwm | {NUM_OUTPUTS{pwm_level}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= out_nxt;
    end
  end

endmodule

// File: doc/pwm_peripheral.md
PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 Parameter PRESCALE, default 13, number of clk cycles per PWM count step (legal range 1..65535).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en_reg_out_7_0  input  8  output enable, bits 7:0 of out.
REQ-005 en_reg_out_15_8  input  8  output enable, bits 15:8 of out.
REQ-006 en_reg_pwm_7_0  input  8  PWM mode select, bits 7:0 of out.
REQ-007 en_reg_pwm_15_8  input  8  PWM mode select, bits 15:8 of out.
REQ-008 pwm_duty_cycle  input  8  duty value; 0x00 = 0 %, 0xFF = 100 %.
REQ-009 out  output  16  driven output pins, registered.
REQ-010 period_start  output  1  single-clk pulse marking the first cycle of each PWM period.

Function
REQ-011 The prescaler SHALL count 0..PRESCALE-1, wrap to 0, and assert an internal tick in the cycle its value is PRESCALE-1.
REQ-012 The 8-bit period counter SHALL increment by one on each tick and wrap 0xFF -> 0x00, giving 256 ticks = 256*PRESCALE clk per period.
REQ-013 A period starts in the cycle where prescaler == 0 and period counter == 0; period_start SHALL be high in exactly that cycle.
REQ-014 In the period-start cycle, duty_shadow SHALL load pwm_duty_cycle; at all other times duty_shadow SHALL hold.
REQ-015 Changes to pwm_duty_cycle mid-period SHALL NOT affect the current period (glitch-free update).
REQ-016 pwm_level SHALL be 1 when duty_shadow == 0xFF, else (period counter < duty_shadow).
REQ-017 Duty 0x00 SHALL give constant low; duty 0xFF SHALL give constant high with no 1-tick low pulse.
REQ-018 For each i in 0..15: next out[i] = 0 if en_out[i] == 0; 1 if en_out[i] == 1 and en_pwm[i] == 0; pwm_level if both 1.
REQ-019 out SHALL be registered: value at edge n+1 is computed from inputs and state sampled at edge n (1 clk latency).
REQ-020 Enable/mode register changes SHALL take effect at the next clk edge, independent of period phase.
REQ-021 en_pwm[i] == 1 with en_out[i] == 0 SHALL give out[i] = 0.
REQ-022 All 16 PWM channels SHALL share one counter and duty_shadow, so enabled PWM outputs are phase-aligned.
REQ-023 With PRESCALE == 1 the tick SHALL be asserted every cycle.

Reset
REQ-024 While rst_n is low: prescaler = 0, period counter = 0, duty_shadow = 0x00, out = 0x0000, period_start = 0.
REQ-025 Reset assertion SHALL clear out immediately (asynchronously), including mid-period.
REQ-026 The first clk edge after rst_n deasserts SHALL be a period start: period_start = 1 and duty_shadow loads.

Structure
REQ-027 A shared package SHALL hold PWM_WIDTH = 8, NUM_OUTPUTS = 16 and PRESCALE_DEFAULT = 13.
REQ-028 The prescaler SHALL be a sub-module pwm_prescaler (parameter PRESCALE; ports clk, rst_n, tick).
REQ-029 Counter, shadow, compare and output mux SHALL reside in pwm_peripheral.

Verification (PRESCALE = 2; period = 512 clk)
REQ-030 duty 0x80, en_out = en_pwm = 0x0001 -> out[0] high 256 clk, low 256 clk, repeating; out[15:1] = 0.
REQ-031 duty 0x00, then 0xFF, en_out = en_pwm = 0xFFFF -> out = 0x0000 for a full period, then 0xFFFF constant from the next period start.
REQ-032 en_out = 0x0002, en_pwm = 0x0000, any duty -> out = 0x0002 constant, one clk after the enable write.
REQ-033 duty 0x40 in period, changed to 0xC0 at counter 0x20 -> high ends at count 0x40 (128 clk after start); the next period is high 384 clk.
REQ-034 rst_n low at counter 0x50 with out = 0xFFFF -> out = 0x0000 before the next clk edge; after release, period_start on the first edge and counting restarts at 0.
REQ-035 period_start pulses SHALL be exactly 512 clk apart over 4 consecutive periods.
